// File: rtl/latch_sync_debounce.sv
// latch_sync_debounce
// Brings the asynchronous level from the reset latch into the clk domain.
// Each level change is qualified by a debounce FSM before it is reported.
// Accepted changes produce a registered level, one-cycle rise/fall pulses
// and a wrapping event count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// LOW     | level is 0 and stable; waiting for sync=1 with en=1
// TO_HIGH | candidate 0->1 change; qcnt counts consecutive sync=1
// HIGH    | level is 1 and stable; waiting for sync=0 with en=1
// TO_LOW  | candidate 1->0 change; qcnt counts consecutive sync=0
module latch_sync_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4,
    parameter int EVT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             latch_q,
    input  logic             en,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             busy
);

    localparam int QW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [QW-1:0] D_VAL = QW'(DEBOUNCE_CNT);

    // Reject configurations that cannot synchronize or qualify.
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("latch_sync_debounce: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CNT < 1) begin : g_bad_deb
            $error("latch_sync_debounce: DEBOUNCE_CNT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        TO_HIGH = 2'd1,
        HIGH    = 2'd2,
        TO_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    state_t                 state;
    state_t                 state_nxt;
    logic [QW-1:0]          qcnt;
    logic [QW-1:0]          qcnt_nxt;
    logic [QW-1:0]          qinc;
    logic                   level_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   busy_nxt;
    logic                   accept;
    logic [EVT_W-1:0]       evt_nxt;

    // Synchronizer chain; the only logic that samples latch_q, runs regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], latch_q};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // State, qualification counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOW;
            qcnt    <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
            evt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            qcnt    <= qcnt_nxt;
            level   <= level_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
            busy    <= busy_nxt;
            evt_cnt <= evt_nxt;
        end
    end

    // Next-state, qualification and accept decisions.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        accept    = 1'b0;
        qinc      = qcnt + QW'(1);

        case (state)
            LOW: begin
                if (en && sync) begin
                    if (DEBOUNCE_CNT == 1) begin
                        state_nxt = HIGH;
                        qcnt_nxt  = '0;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = TO_HIGH;
                        qcnt_nxt  = QW'(1);
                    end
                end
            end

            TO_HIGH: begin
                // Losing en or seeing sync drop abandons the candidate silently.
                if (!en || !sync) begin
                    state_nxt = LOW;
                    qcnt_nxt  = '0;
                end else if (qinc == D_VAL) begin
                    state_nxt = HIGH;
                    qcnt_nxt  = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    accept    = 1'b1;
                end else begin
                    qcnt_nxt  = qinc;
                end
            end

            HIGH: begin
                if (en && !sync) begin
                    if (DEBOUNCE_CNT == 1) begin
                        state_nxt = LOW;
                        qcnt_nxt  = '0;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = TO_LOW;
                        qcnt_nxt  = QW'(1);
                    end
                end
            end

            TO_LOW: begin
                if (!en || sync) begin
                    state_nxt = HIGH;
                    qcnt_nxt  = '0;
                end else if (qinc == D_VAL) begin
                    state_nxt = LOW;
                    qcnt_nxt  = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    accept    = 1'b1;
                end else begin
                    qcnt_nxt  = qinc;
                end
            end

            default: begin
                state_nxt = LOW;
                qcnt_nxt  = '0;
                level_nxt = 1'b0;
            end
        endcase

        // Clear wins over a coincident increment.
        if (cnt_clr) begin
            evt_nxt = '0;
        end else if (accept) begin
            evt_nxt = evt_cnt + EVT_W'(1);
        end else begin
            evt_nxt = evt_cnt;
        end

        busy_nxt = (state_nxt == TO_HIGH) || (state_nxt == TO_LOW);
    end

endmodule

// File: tb/tb_latch_sync_debounce.sv
// Bench for latch_sync_debounce: three configurations share one stimulus
// stream and are each compared every cycle against a run-length model.
module tb_latch_sync_debounce;

    localparam int N = 3;

    logic clk;
    logic rst;
    logic latch_q;
    logic en;
    logic cnt_clr;

    logic [N-1:0] lv;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic [N-1:0] bz;
    logic [7:0]   ec0;
    logic [1:0]   ec1;
    logic [3:0]   ec2;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit       m_lvl  [N];
    bit       m_rise [N];
    bit       m_fall [N];
    int       m_run  [N];
    int       m_evt  [N];
    bit [7:0] m_hist [N];

    latch_sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CNT(4), .EVT_W(8)) dut0 (
        .clk(clk), .rst(rst), .latch_q(latch_q), .en(en), .cnt_clr(cnt_clr),
        .level(lv[0]), .rise(rs[0]), .fall(fl[0]), .evt_cnt(ec0), .busy(bz[0]));

    latch_sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CNT(4), .EVT_W(2)) dut1 (
        .clk(clk), .rst(rst), .latch_q(latch_q), .en(en), .cnt_clr(cnt_clr),
        .level(lv[1]), .rise(rs[1]), .fall(fl[1]), .evt_cnt(ec1), .busy(bz[1]));

    latch_sync_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CNT(1), .EVT_W(4)) dut2 (
        .clk(clk), .rst(rst), .latch_q(latch_q), .en(en), .cnt_clr(cnt_clr),
        .level(lv[2]), .rise(rs[2]), .fall(fl[2]), .evt_cnt(ec2), .busy(bz[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int s_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int d_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int w_of(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int ec_of(input int i);
        case (i)
            0:       return int'(ec0);
            1:       return int'(ec1);
            default: return int'(ec2);
        endcase
    endfunction

    // One rising edge of the reference: sync is latch_q delayed S edges; a change
    // is accepted once D consecutive enabled samples disagree with the level.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit sy;
            bit acc;
            acc = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (rst) begin
                m_hist[i] = '0;
                m_run[i]  = 0;
                m_lvl[i]  = 1'b0;
                m_evt[i]  = 0;
            end else begin
                sy = m_hist[i][s_of(i)-1];
                m_hist[i] = {m_hist[i][6:0], latch_q};
                if (en && (sy != m_lvl[i])) begin
                    m_run[i]++;
                    if (m_run[i] == d_of(i)) begin
                        m_run[i] = 0;
                        m_lvl[i] = sy;
                        if (sy) m_rise[i] = 1'b1;
                        else    m_fall[i] = 1'b1;
                        acc = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (cnt_clr)  m_evt[i] = 0;
                else if (acc) m_evt[i] = (m_evt[i] + 1) % (1 << w_of(i));
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("level[%0d]", i), int'(lv[i]), int'(m_lvl[i]));
            chk($sformatf("rise[%0d]", i),  int'(rs[i]), int'(m_rise[i]));
            chk($sformatf("fall[%0d]", i),  int'(fl[i]), int'(m_fall[i]));
            chk($sformatf("busy[%0d]", i),  int'(bz[i]), (m_run[i] > 0) ? 1 : 0);
            chk($sformatf("evt_cnt[%0d]", i), ec_of(i), m_evt[i]);
        end
    endtask

    // Advance one edge, update the model, check #1 later, return at the negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic wait_evt(input bit pol, output int n0, output int n2, output int b0);
        n0 = 0;
        n2 = 0;
        b0 = 0;
        for (int k = 1; k <= 30 && (n0 == 0 || n2 == 0); k++) begin
            step();
            if (b0 == 0 && bz[0]) b0 = k;
            if (n0 == 0 && (pol ? rs[0] : fl[0])) n0 = k;
            if (n2 == 0 && (pol ? rs[2] : fl[2])) n2 = k;
        end
    endtask

    initial begin
        int n0, n2, b0, k_hit, ec_before, hold;
        bit saw_busy, saw_rise;

        rst = 1'b1; latch_q = 1'b1; en = 1'b1; cnt_clr = 1'b0;
        @(negedge clk);

        // reset held with latch_q high
        step();
        step();
        chk("reset_outputs", int'({lv[0], rs[0], fl[0], bz[0]}), 0);
        chk("reset_evt", int'(ec0), 0);

        // release with latch_q=1: full sequence before level rises
        rst = 1'b0;
        wait_evt(1'b1, n0, n2, b0);
        chk("release_rise_edge_d4", n0, 6);
        chk("release_rise_edge_d1s3", n2, 4);
        chk("release_level", int'(lv[0]), 1);

        // fall from stable high
        latch_q = 1'b0;
        wait_evt(1'b0, n0, n2, b0);
        chk("fall_edge_d4", n0, 6);
        chk("fall_edge_d1s3", n2, 4);
        chk("fall_evt", int'(ec0), 2);
        step();
        chk("fall_one_cycle", int'(fl[0]), 0);
        for (int k = 0; k < 6; k++) step();

        // glitch: three cycles high is short of four
        ec_before = int'(ec0);
        saw_busy = 1'b0;
        saw_rise = 1'b0;
        latch_q = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            saw_busy |= bz[0];
            saw_rise |= rs[0];
        end
        latch_q = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            saw_busy |= bz[0];
            saw_rise |= rs[0];
        end
        chk("glitch_busy_seen", int'(saw_busy), 1);
        chk("glitch_no_rise", int'(saw_rise), 0);
        chk("glitch_level", int'(lv[0]), 0);
        chk("glitch_evt", int'(ec0), ec_before);

        // clean rise from LOW
        latch_q = 1'b1;
        wait_evt(1'b1, n0, n2, b0);
        chk("rise_busy_edge", b0, 3);
        chk("rise_edge", n0, 6);
        chk("rise_level", int'(lv[0]), 1);
        step();
        chk("rise_one_cycle", int'(rs[0]), 0);

        // back to LOW
        latch_q = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // enable abort after the second qualification sample
        latch_q = 1'b1;
        for (int k = 0; k < 4; k++) step();
        en = 1'b0;
        step();
        chk("abort_busy", int'(bz[0]), 0);
        chk("abort_level", int'(lv[0]), 0);
        en = 1'b1;
        k_hit = 0;
        for (int k = 1; k <= 12 && k_hit == 0; k++) begin
            step();
            if (rs[0]) k_hit = k;
        end
        chk("reentry_rise_edge", k_hit, 4);

        // counter wrap on the 2-bit counter
        latch_q = 1'b0;
        for (int k = 0; k < 10; k++) step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            latch_q = ~latch_q;
            for (int k = 0; k < 8; k++) step();
        end
        chk("wrap_evt2", int'(ec1), 0);
        chk("wrap_evt8", int'(ec0), 4);

        // clear coincident with a rise
        latch_q = 1'b1;
        for (int k = 0; k < 5; k++) step();
        cnt_clr = 1'b1;
        step();
        chk("clr_rise", int'(rs[1]), 1);
        chk("clr_level", int'(lv[1]), 1);
        chk("clr_evt", int'(ec1), 0);
        cnt_clr = 1'b0;
        step();

        // randomized segments with occasional enable drops, clears and resets
        for (int seg = 0; seg < 500; seg++) begin
            latch_q = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                en      = ($urandom_range(0, 9) != 0);
                cnt_clr = ($urandom_range(0, 31) == 0);
                rst     = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        rst = 1'b0; en = 1'b1; cnt_clr = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_sync_debounce.md
# latch_sync_debounce

Downstream consumer of the asynchronous-reset D latch. It takes the latch's level output, which is asynchronous to the system clock, and brings it into the `clk` domain through a synchronizer chain. A debounce state machine then qualifies each level change before it is reported. The block provides a clean registered level, single-cycle rise/fall event pulses and a wrapping event counter to downstream control logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count. Values below 2 are an elaboration error.
- `DEBOUNCE_CNT`, default 4: consecutive synchronized samples required to accept a level change. Values below 1 are an elaboration error.
- `EVT_W`, default 8: width of the event counter.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `latch_q`, input, 1: latch output. Asynchronous to `clk`.
- `en`, input, 1: qualification enable.
- `cnt_clr`, input, 1: synchronous clear of `evt_cnt`.
- `level`, output, 1: debounced, registered level.
- `rise`, output, 1: one-cycle pulse on an accepted 0→1 change.
- `fall`, output, 1: one-cycle pulse on an accepted 1→0 change.
- `evt_cnt`, output, EVT_W: count of accepted events (rise plus fall). Wraps.
- `busy`, output, 1: high while a candidate change is being qualified.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops in series; the last stage is `sync`. The chain runs regardless of `en`. It is the only logic that samples `latch_q`.
- **Qualification counter:** `qcnt`, width clog2(DEBOUNCE_CNT+1). It holds the number of consecutive samples of `sync` that differ from `level`.
- **FSM states:** LOW, TO_HIGH, HIGH, TO_LOW. All transitions are evaluated on each rising edge.
  - LOW, `en`=1, `sync`=1:
    - If DEBOUNCE_CNT=1: go to HIGH and accept.
    - Otherwise: go to TO_HIGH with `qcnt`=1.
  - TO_HIGH, `sync`=1, `en`=1: `qcnt`+1. When the incremented value equals DEBOUNCE_CNT, go to HIGH and accept.
  - TO_HIGH, `sync`=0: return to LOW and clear `qcnt`. This is a glitch rejection: no pulse, no count.
  - HIGH and TO_LOW: mirror of LOW and TO_HIGH with the polarity inverted.
  - `en`=0 in TO_HIGH or TO_LOW: return to the originating stable state and clear `qcnt`. No pulse is generated.
  - `en`=0 in LOW or HIGH: hold.
- **Accept action**, on the same edge as the transition into the new stable state:
  - `level` takes the new value.
  - `rise` (0→1) or `fall` (1→0) is high for exactly one cycle.
  - `evt_cnt` increments by 1 modulo 2^EVT_W.
- **`busy`:** 1 exactly when the state is TO_HIGH or TO_LOW.
- **`cnt_clr`:** sets `evt_cnt` to 0 on the next edge. It takes priority over a coincident increment, so the result is 0. It has no effect on the FSM.
- **Reset values (`rst`=1 at an edge):**
  - All synchronizer flops = 0.
  - State = LOW, `qcnt` = 0.
  - `level` = 0, `rise` = 0, `fall` = 0, `busy` = 0, `evt_cnt` = 0.
  - `rst` overrides all other inputs.
  - A reset during qualification aborts it with no pulse.
  - After `rst` deasserts with `latch_q`=1, a full synchronize-and-debounce sequence is required before `level` goes high.

## Timing
- **Acceptance latency:** if `latch_q` changes and meets setup before edge E1, then `level`, `rise`/`fall` and `evt_cnt` update at edge E(SYNC_STAGES+DEBOUNCE_CNT).
  - Example, defaults: edge 6.
  - Example, DEBOUNCE_CNT=1 with SYNC_STAGES=2: edge 3.
- **Glitch rejection:** a `sync` pulse shorter than DEBOUNCE_CNT cycles never changes `level`.
- **`busy` timing:**
  - Rises at edge E(SYNC_STAGES+1) when DEBOUNCE_CNT>1.
  - Falls on the same edge as acceptance or abort.
- **Event spacing:** `rise` and `fall` are never both high. Consecutive events are at least DEBOUNCE_CNT cycles apart.
- **Outputs:** all registered; no combinational path from any input to any output.

## Test plan
1. **Reset:** hold `rst`=1 for 2 cycles with `latch_q`=1.
   - Required: `level`=0, `rise`=0, `fall`=0, `busy`=0, `evt_cnt`=0.
   - After release: `level`=1 at the 6th edge.
2. **Clean rise (defaults):** `latch_q` goes 0→1 before E1.
   - Required: `busy`=1 from E3; `level`=1 and `rise`=1 after E6; `rise`=0 after E7; `evt_cnt`=1.
3. **Glitch:** `latch_q` high for 3 cycles, then low.
   - Required: `busy` pulses; `level` stays 0; no `rise`; `evt_cnt` unchanged.
4. **Fall:** from stable high, `latch_q` goes 1→0.
   - Required: `level`=0 and `fall`=1 at E6 for one cycle; `evt_cnt` increments by 1.
5. **Enable abort:** drop `en` after the 2nd qualification sample.
   - Required: return to LOW, no `rise`.
   - Re-raise `en` with `latch_q` still 1: `rise` follows after a full DEBOUNCE_CNT samples from re-entry.
6. **Counter wrap and clear (EVT_W=2):**
   - 4 accepted events give `evt_cnt`=0.
   - `cnt_clr` coincident with a `rise` gives `evt_cnt`=0; `level`=1 and `rise`=1 still occur.
